chunked_addsub_unit: RTL and testbench
======================================

// Module: chunked_addsub_unit
// PURPOSE
//  Parametrised multi-cycle add/subtract/compare unit, WIDTH bits wide.
//  Processes CHUNK bits per clock, rippling the carry across cycles.
//  Provides full status flags and valid/ready handshakes on both sides.
//  Sits between operand registers and the result/compare consumers.
//  Generalises the combinational 4-bit subtractor to wide operands, several
//  modes and sequential operation.
// PARAMETERS
//  WIDTH   16  operand/result width in bits; must be a multiple of CHUNK
//  CHUNK   4   bits processed per cycle; CHUNK==WIDTH gives a 1-cycle unit
//  SIGNED  0   1: Lt uses two's-complement ordering; 0: unsigned ordering
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      operands and MODE valid
//  in_ready   out  1      unit can accept an operation
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  MODE       in   2      00 ADD A+B, 01 SUB A-B, 10 CMP (A-B, flags only), 11 RSUB B-A
//  out_valid  out  1      result and flags valid
//  out_ready  in   1      consumer takes the result
//  Result     out  WIDTH  sum/difference mod 2^WIDTH; all-zero in CMP mode
//  Cout       out  1      ADD: carry out; SUB/CMP/RSUB: borrow (1 = minuend < subtrahend, unsigned)
//  Ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
//  Zero       out  1      internal difference/sum == 0
//  Neg        out  1      MSB of the internal difference/sum
//  Eq         out  1      A == B (all modes)
//  Lt         out  1      A < B; signed ordering when SIGNED=1, else unsigned
// BEHAVIOUR
//  Reset: async, immediate.
//   - State returns to IDLE and in_ready=1.
//   - out_valid=0; Result, Cout, Ovf, Zero, Neg, Eq, Lt all 0.
//   - The chunk index clears and any in-flight operation is discarded; it never completes.
//  FSM: IDLE -> BUSY -> DONE -> IDLE.
//   - IDLE: in_ready=1. On in_valid&&in_ready, latch A, B and MODE.
//     Operand swap for RSUB; B inverted and carry-in=1 for SUB/CMP/RSUB; carry-in=0 for ADD.
//     Clear chunk index k. Go to BUSY.
//   - BUSY: in_ready=0. Each cycle compute slice k = opA[k] + opB[k] + carry.
//     Write the slice result and register the carry.
//     After NCHUNK = WIDTH/CHUNK cycles, go to DONE.
//   - DONE: out_valid=1. Outputs held stable while out_ready=0.
//     On out_ready, go to IDLE; in_ready rises the next cycle.
//  Latency: with acceptance at edge 0, out_valid is high from edge NCHUNK.
//   The next operation can be accepted one cycle after the output handshake.
//  Inputs are ignored outside IDLE. in_valid during BUSY/DONE is not an error and is not queued.
//  Flags are computed at the final chunk from the MSB slice carry-in and carry-out:
//   - Lt = SIGNED ? (Neg ^ Ovf) : borrow of A-B.
//   - Eq = (A-B == 0). Eq and Lt always refer to A-B, including in RSUB and ADD;
//     ADD runs a second compare path using a shared difference register.
//  Widths: no width extension. Overflow wraps mod 2^WIDTH and is reported only via Cout/Ovf.
//  WIDTH % CHUNK != 0 is an elaboration-time error, raised by a generate-block check.
// STRUCTURE
//  arith_pkg:
//   - MODE_ADD/MODE_SUB/MODE_CMP/MODE_RSUB 2-bit constants.
//   - FSM state encoding: ST_IDLE, ST_BUSY, ST_DONE.
//   - Shared with the comparator and adder blocks.
//  Sub-module chunk_adder (CHUNK bits, combinational):
//   - Inputs: a, b, cin. Outputs: sum, cout, c_msb (carry into the top bit, used for Ovf).
//   - One instance for the main path; one for the A-B compare path in ADD mode.
//  Top level contains the FSM, operand/result shift registers and chunk counter
//  ($clog2(NCHUNK)+1 bits).
// TESTING (WIDTH=16, CHUNK=4 unless stated)
//  1 SUB A=0x1234 B=0x0234 -> Result=0x1000, Cout=0, Zero=0; out_valid exactly 4 cycles after acceptance.
//  2 SUB A=0x0000 B=0x0001 -> Result=0xFFFF, Cout=1, Neg=1, Ovf=0.
//    RSUB same operands -> Result=0x0001, Cout=0.
//  3 ADD 0x7FFF+0x0001 -> Result=0x8000, Ovf=1, Cout=0.
//    ADD 0xFFFF+0x0001 -> Result=0x0000, Cout=1, Zero=1, Eq=0.
//  4 CMP A=0xFFFE B=0x0003: SIGNED=1 -> Lt=1, Eq=0, Result=0; SIGNED=0 -> Lt=0.
//    A=B=0xABCD -> Eq=1, Zero=1.
//  5 Backpressure: out_ready=0 for 5 cycles -> Result/flags stable, in_ready=0,
//    a new in_valid is ignored; after the handshake, in_ready=1 one cycle later.
//  6 Reset mid-operation (rst pulsed in BUSY, chunk 2) -> out_valid=0 and Result=0 at once,
//    in_ready=1; a following SUB 0x0005-0x0003 gives 0x0002.
//    Repeat scenario 1 with CHUNK=16: latency 1.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared constants for the chunked add/subtract unit: operation modes and FSM states.
package arith_pkg;

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_CMP  = 2'b10;
  localparam logic [1:0] MODE_RSUB = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

endpackage

// File: rtl/chunked_addsub_unit_chunk_adder.sv
// Combinational CHUNK-bit adder slice with carry out and carry into the top bit.
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    // carry into the top bit recovered from the top-bit sum equation
    c_msb       = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];
  end

endmodule

// File: rtl/chunked_addsub_unit.sv
// Multi-cycle add/sub/compare unit: CHUNK bits per cycle, carry rippled across cycles,
// with a parallel A-B slice path so Eq/Lt always describe A-B.
module chunked_addsub_unit
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned CHUNK  = 4,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       MODE,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero,
  output logic             Neg,
  output logic             Eq,
  output logic             Lt
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned KW     = $clog2(NCHUNK) + 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("chunked_addsub_unit: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_t           state, state_next;
  logic [KW-1:0]    k;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] op_a, op_b, cmp_a, cmp_b, res_sr, res_next;
  logic             carry, cmp_carry, diff_nz, last;

  logic [CHUNK-1:0] m_sum, c_sum;
  logic             m_cout, m_cmsb, c_cout, c_cmsb;

  chunk_adder #(.CHUNK(CHUNK)) u_main (
    .a(op_a[CHUNK-1:0]), .b(op_b[CHUNK-1:0]), .cin(carry),
    .sum(m_sum), .cout(m_cout), .c_msb(m_cmsb)
  );

  chunk_adder #(.CHUNK(CHUNK)) u_cmp (
    .a(cmp_a[CHUNK-1:0]), .b(cmp_b[CHUNK-1:0]), .cin(cmp_carry),
    .sum(c_sum), .cout(c_cout), .c_msb(c_cmsb)
  );

  generate
    if (CHUNK == WIDTH) begin : g_single
      assign res_next = m_sum;
    end else begin : g_multi
      assign res_next = {m_sum, res_sr[WIDTH-1:CHUNK]};
    end
  endgenerate

  assign last      = (k == K_LAST);
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign Result    = res_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (in_valid)  state_next = ST_BUSY;
      ST_BUSY: if (last)      state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k         <= '0;
      mode_q    <= MODE_ADD;
      op_a      <= '0;
      op_b      <= '0;
      cmp_a     <= '0;
      cmp_b     <= '0;
      res_sr    <= '0;
      carry     <= 1'b0;
      cmp_carry <= 1'b0;
      diff_nz   <= 1'b0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
      Zero      <= 1'b0;
      Neg       <= 1'b0;
      Eq        <= 1'b0;
      Lt        <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mode_q    <= MODE;
            k         <= '0;
            cmp_a     <= A;
            cmp_b     <= ~B;
            cmp_carry <= 1'b1;
            diff_nz   <= 1'b0;
            unique case (MODE)
              MODE_ADD:  begin op_a <= A; op_b <= B;  carry <= 1'b0; end
              MODE_RSUB: begin op_a <= B; op_b <= ~A; carry <= 1'b1; end
              default:   begin op_a <= A; op_b <= ~B; carry <= 1'b1; end
            endcase
          end
        end
        ST_BUSY: begin
          op_a      <= op_a >> CHUNK;
          op_b      <= op_b >> CHUNK;
          cmp_a     <= cmp_a >> CHUNK;
          cmp_b     <= cmp_b >> CHUNK;
          carry     <= m_cout;
          cmp_carry <= c_cout;
          diff_nz   <= diff_nz | (|c_sum);
          k         <= k + 1'b1;
          res_sr    <= res_next;
          // final slice: the carries on the wires now belong to the MSB slice
          if (last) begin
            if (mode_q == MODE_CMP) res_sr <= '0;
            Cout <= (mode_q == MODE_ADD) ? m_cout : ~m_cout;
            Ovf  <= m_cmsb ^ m_cout;
            Zero <= (res_next == '0);
            Neg  <= res_next[WIDTH-1];
            Eq   <= ~(diff_nz | (|c_sum));
            Lt   <= SIGNED ? (c_sum[CHUNK-1] ^ c_cmsb ^ c_cout) : ~c_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_addsub_unit.sv
// Directed self-checking bench for chunked_addsub_unit (signed, unsigned and single-chunk builds).
module tb_chunked_addsub_unit;
  import arith_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic [1:0]  MODE = MODE_ADD;

  logic        in_ready, out_valid, Cout, Ovf, Zero, Neg, Eq, Lt;
  logic [15:0] Result;
  logic        u_in_ready, u_out_valid, u_cout, u_ovf, u_zero, u_neg, u_eq, u_lt;
  logic [15:0] u_result;
  logic        w_in_ready, w_out_valid, w_cout, w_ovf, w_zero, w_neg, w_eq, w_lt;
  logic [15:0] w_result;

  int total = 0;
  int bad   = 0;
  int lat, lat_w;

  always #5 clk = ~clk;

  chunked_addsub_unit #(.WIDTH(16), .CHUNK(4), .SIGNED(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .MODE(MODE), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Cout(Cout), .Ovf(Ovf), .Zero(Zero), .Neg(Neg), .Eq(Eq), .Lt(Lt)
  );

  chunked_addsub_unit #(.WIDTH(16), .CHUNK(4), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready),
    .A(A), .B(B), .MODE(MODE), .out_valid(u_out_valid), .out_ready(out_ready),
    .Result(u_result), .Cout(u_cout), .Ovf(u_ovf), .Zero(u_zero), .Neg(u_neg), .Eq(u_eq), .Lt(u_lt)
  );

  chunked_addsub_unit #(.WIDTH(16), .CHUNK(16), .SIGNED(1'b1)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .A(A), .B(B), .MODE(MODE), .out_valid(w_out_valid), .out_ready(out_ready),
    .Result(w_result), .Cout(w_cout), .Ovf(w_ovf), .Zero(w_zero), .Neg(w_neg), .Eq(w_eq), .Lt(w_lt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation at a negedge; returns once both 4-chunk and 16-chunk units are done.
  task automatic issue(input logic [1:0] mode, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    A = a; B = b; MODE = mode; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = -1; lat_w = -1;
    for (int c = 0; c < 20; c++) begin
      if (out_valid && lat < 0) lat = c;
      if (w_out_valid && lat_w < 0) lat_w = c;
      if (lat >= 0 && lat_w >= 0) break;
      @(negedge clk);
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", Result, 0);
    check("rst_flags", {Cout, Ovf, Zero, Neg, Eq, Lt}, 0);
    rst = 1'b0;

    // 1: SUB 0x1234-0x0234
    issue(MODE_SUB, 16'h1234, 16'h0234);
    check("s1_latency", lat, 4);
    check("s1_latency_c16", lat_w, 1);
    check("s1_result", Result, 16'h1000);
    check("s1_result_c16", w_result, 16'h1000);
    check("s1_cout", Cout, 0);
    check("s1_zero", Zero, 0);
    check("s1_lt", Lt, 0);
    release_out();

    // 2: SUB 0-1 and RSUB
    issue(MODE_SUB, 16'h0000, 16'h0001);
    check("s2_result", Result, 16'hFFFF);
    check("s2_cout", Cout, 1);
    check("s2_neg", Neg, 1);
    check("s2_ovf", Ovf, 0);
    check("s2_lt_s", Lt, 1);
    check("s2_lt_u", u_lt, 1);
    release_out();
    issue(MODE_RSUB, 16'h0000, 16'h0001);
    check("s2r_result", Result, 16'h0001);
    check("s2r_cout", Cout, 0);
    check("s2r_lt", Lt, 1);
    check("s2r_eq", Eq, 0);
    check("s2r_result_c16", w_result, 16'h0001);
    release_out();

    // 3: ADD overflow and carry
    issue(MODE_ADD, 16'h7FFF, 16'h0001);
    check("s3a_result", Result, 16'h8000);
    check("s3a_ovf", Ovf, 1);
    check("s3a_cout", Cout, 0);
    release_out();
    issue(MODE_ADD, 16'hFFFF, 16'h0001);
    check("s3b_result", Result, 16'h0000);
    check("s3b_cout", Cout, 1);
    check("s3b_zero", Zero, 1);
    check("s3b_eq", Eq, 0);
    check("s3b_ovf", Ovf, 0);
    check("s3b_lt_s", Lt, 1);
    check("s3b_lt_u", u_lt, 0);
    release_out();

    // 4: CMP
    issue(MODE_CMP, 16'hFFFE, 16'h0003);
    check("s4a_lt_s", Lt, 1);
    check("s4a_lt_u", u_lt, 0);
    check("s4a_eq", Eq, 0);
    check("s4a_result", Result, 0);
    check("s4a_cout", Cout, 0);
    release_out();
    issue(MODE_CMP, 16'hABCD, 16'hABCD);
    check("s4b_eq", Eq, 1);
    check("s4b_zero", Zero, 1);
    check("s4b_result", Result, 0);
    check("s4b_lt", Lt, 0);
    release_out();

    // 5: backpressure with an ignored request
    issue(MODE_SUB, 16'h0010, 16'h0001);
    A = 16'hFFFF; B = 16'h0000; MODE = MODE_ADD; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("s5_hold_result", Result, 16'h000F);
      check("s5_hold_valid", out_valid, 1);
      check("s5_hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    release_out();
    check("s5_in_ready_after", in_ready, 1);
    check("s5_out_valid_after", out_valid, 0);
    @(negedge clk);
    check("s5_no_ghost_op", {in_ready, out_valid}, 2'b10);
    check("s5_result_kept", Result, 16'h000F);

    // 6: reset in BUSY at chunk 2
    @(negedge clk);
    A = 16'h0007; B = 16'h0002; MODE = MODE_SUB; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("s6_busy_before_rst", in_ready, 0);
    rst = 1'b1;
    #1;
    check("s6_rst_out_valid", out_valid, 0);
    check("s6_rst_result", Result, 0);
    check("s6_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("s6_discarded", out_valid, 0);
    issue(MODE_SUB, 16'h0005, 16'h0003);
    check("s6_result", Result, 16'h0002);
    check("s6_latency", lat, 4);
    check("s6_result_c16", w_result, 16'h0002);
    release_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
